// File: rtl/adex_neuron_array.sv
// adex_neuron_array: time-multiplexed AdEx neuron array with tick-driven sweep and spike FIFO
// Ports: clk/rst (sync, active-high); in_valid/in_idx/in_current write a neuron's input current;
// mon_idx selects v_mon/w_mon; spike_valid/spike_idx/spike_ready drain spike events;
// spike_drop and overrun are sticky error flags; busy is high while a sweep runs.
// Option: define ADEX_REFRACTORY_EN to hold a neuron at V_RESET for REFRAC_TICKS ticks after it spikes.
module adex_neuron_array #(
  parameter int N_NEURONS      = 4,
  parameter int V_WIDTH        = 16,
  parameter int LUT_DEPTH      = 16,
  parameter int TICK_DIV       = 16,
  parameter int SPK_FIFO_DEPTH = 4,
  parameter int E_L            = -1120,
  parameter int V_T            = -800,
  parameter int V_PEAK         = 320,
  parameter int V_RESET        = -1120,
  parameter int B_INC          = 64,
  parameter int REFRAC_TICKS   = 2,
  localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [IW-1:0]             in_idx,
  input  logic signed [V_WIDTH-1:0] in_current,
  input  logic [IW-1:0]             mon_idx,
  output logic signed [V_WIDTH-1:0] v_mon,
  output logic signed [V_WIDTH-1:0] w_mon,
  output logic                      spike_valid,
  output logic [IW-1:0]             spike_idx,
  input  logic                      spike_ready,
  output logic                      spike_drop,
  output logic                      overrun,
  output logic                      busy
);
  localparam int XW = V_WIDTH + 3;
  localparam int AW = SPK_FIFO_DEPTH > 1 ? $clog2(SPK_FIFO_DEPTH) : 1;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic signed [V_WIDTH-1:0] VMAX = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] VMIN = {1'b1, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [V_WIDTH-1:0] EL   = V_WIDTH'(E_L);
  localparam logic signed [V_WIDTH-1:0] VTH  = V_WIDTH'(V_T);
  localparam logic signed [V_WIDTH-1:0] PEAK = V_WIDTH'(V_PEAK);
  localparam logic signed [V_WIDTH-1:0] VRST = V_WIDTH'(V_RESET);
  localparam logic signed [V_WIDTH-1:0] BINC = V_WIDTH'(B_INC);

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx;
  logic signed [V_WIDTH-1:0] v [N_NEURONS];
  logic signed [V_WIDTH-1:0] w [N_NEURONS];
  logic signed [V_WIDTH-1:0] cur [N_NEURONS];
  logic [IW-1:0] fifo [SPK_FIFO_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic tick, hold, spk, pop, full, acc;
  logic signed [XW-1:0] vx, wx, ix, dk, ex;
  logic signed [V_WIDTH-1:0] vn_s, wn_s, wb_s;
  int k;

  function automatic logic signed [V_WIDTH-1:0] sat(input logic signed [XW-1:0] x);
    return x > XW'(VMAX) ? VMAX : x < XW'(VMIN) ? VMIN : x[V_WIDTH-1:0];
  endfunction

  // Datapath for the neuron currently visited by the sweep; all terms widened so nothing wraps before saturation.
  always_comb begin
    vx = XW'(v[idx]);
    wx = XW'(w[idx]);
    ix = XW'(cur[idx]);
    dk = (vx - XW'(VTH)) >>> 4;
    k = vx < XW'(VTH) ? 0 : dk > XW'(LUT_DEPTH - 1) ? LUT_DEPTH - 1 : int'(dk);
    ex = vx < XW'(VTH) ? '0 : XW'(1) << (k * 8 / LUT_DEPTH);
    vn_s = sat(vx + ((XW'(EL) - vx) >>> 3) + ex + ix - wx);
    wn_s = sat(wx + ((((vx - XW'(EL)) >>> 4) - wx) >>> 4));
    wb_s = sat(XW'(wn_s) + XW'(BINC));
  end

  assign tick        = tcnt == TW'(TICK_DIV - 1);
  assign busy        = state == SWEEP;
  assign spk         = busy && vn_s >= PEAK && !hold;
  assign spike_valid = cnt != '0;
  assign spike_idx   = spike_valid ? fifo[rp] : '0;
  assign pop         = spike_valid && spike_ready;
  assign full        = cnt == (AW+1)'(SPK_FIFO_DEPTH);
  assign acc         = spk && (!full || pop);
  assign v_mon       = int'(mon_idx) < N_NEURONS ? v[mon_idx] : '0;
  assign w_mon       = int'(mon_idx) < N_NEURONS ? w[mon_idx] : '0;

`ifdef ADEX_REFRACTORY_EN
  localparam int RW = REFRAC_TICKS > 0 ? $clog2(REFRAC_TICKS + 1) : 1;
  logic [RW-1:0] refr [N_NEURONS];
  assign hold = refr[idx] != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) refr[n] <= '0;
    end else if (busy) begin
      refr[idx] <= spk ? RW'(REFRAC_TICKS) : hold ? refr[idx] - 1'b1 : refr[idx];
    end
  end
`else
  localparam int unused_refrac = REFRAC_TICKS;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      idx        <= '0;
      rp         <= '0;
      wp         <= '0;
      cnt        <= '0;
      spike_drop <= 1'b0;
      overrun    <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v[n]   <= EL;
        w[n]   <= '0;
        cur[n] <= '0;
      end
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      // Same-cycle write to the visited neuron lands after the datapath has read the old current.
      if (in_valid && int'(in_idx) < N_NEURONS) cur[in_idx] <= in_current;
      if (tick && busy) overrun <= 1'b1;
      if (!busy) begin
        if (tick) begin
          state <= SWEEP;
          idx   <= '0;
        end
      end else begin
        v[idx] <= (spk || hold) ? VRST : vn_s;
        w[idx] <= spk ? wb_s : wn_s;
        idx    <= idx + 1'b1;
        if (int'(idx) == N_NEURONS - 1) state <= IDLE;
      end
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      if (acc) begin
        fifo[wp] <= idx;
        wp       <= wp + 1'b1;
      end
      if (spk && !acc) spike_drop <= 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(acc) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_adex_neuron_array.sv
// tb_adex_neuron_array: vector table, directed corner sequences and random model comparison for adex_neuron_array
module tb_adex_neuron_array;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, spike_ready = 1'b1;
  logic [1:0] in_idx = '0, mon_idx = '0, spike_idx;
  logic signed [15:0] in_current = '0, v_mon, w_mon;
  logic spike_valid, spike_drop, overrun, busy;
  logic [1:0] ov_si;
  logic signed [15:0] ov_v, ov_w;
  logic ov_sv, ov_sd, ov_over, ov_busy;
  int checks = 0, failures = 0;

  adex_neuron_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_current(in_current),
    .mon_idx(mon_idx), .v_mon(v_mon), .w_mon(w_mon), .spike_valid(spike_valid),
    .spike_idx(spike_idx), .spike_ready(spike_ready), .spike_drop(spike_drop),
    .overrun(overrun), .busy(busy)
  );
  adex_neuron_array #(.TICK_DIV(3)) dut_ov (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_idx(2'd0), .in_current(16'sd0),
    .mon_idx(2'd0), .v_mon(ov_v), .w_mon(ov_w), .spike_valid(ov_sv),
    .spike_idx(ov_si), .spike_ready(1'b1), .spike_drop(ov_sd),
    .overrun(ov_over), .busy(ov_busy)
  );

  always #5 clk = ~clk;

  int sweeps = 0, valid_cycles = 0;
  int got_q[$], got_sw[$];
  bit pb = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sweeps = 0;
      valid_cycles = 0;
      got_q.delete();
      got_sw.delete();
      pb = 1'b0;
    end else begin
      if (busy && !pb) sweeps++;
      pb = busy;
      if (spike_valid) valid_cycles++;
      if (spike_valid && spike_ready) begin
        got_q.push_back(int'(spike_idx));
        got_sw.push_back(sweeps);
      end
    end
  end

  task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input int n, input int c);
    in_valid = 1'b1;
    in_idx = 2'(n);
    in_current = 16'(c);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy !== lvl && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== lvl) chk("busy_wait", busy, lvl);
  endtask

  task automatic sweep();
    wait_busy(1'b1);
    wait_busy(1'b0);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic peek(input int n, output int pv, output int pw);
    mon_idx = 2'(n);
    #1;
    pv = v_mon;
    pw = w_mon;
  endtask

  function automatic int sat16(input int x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
  endfunction

  int mv[4], mw[4], mi[4], mr[4];
  int exp_q[$];

  task automatic model_init();
    for (int n = 0; n < 4; n++) begin
      mv[n] = -1120; mw[n] = 0; mi[n] = 0; mr[n] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_tick();
    for (int n = 0; n < 4; n++) begin
      int vv, ww, kk, e, vn, wn;
      vv = mv[n];
      ww = mw[n];
      kk = (vv - (-800)) >>> 4;
      if (kk > 15) kk = 15;
      e = vv < -800 ? 0 : 1 << (kk * 8 / 16);
      vn = sat16(vv + ((-1120 - vv) >>> 3) + e + mi[n] - ww);
      wn = sat16(ww + ((((vv + 1120) >>> 4) - ww) >>> 4));
`ifdef ADEX_REFRACTORY_EN
      if (mr[n] > 0) begin
        mr[n]--;
        mv[n] = -1120;
        mw[n] = wn;
        continue;
      end
`endif
      if (vn >= 320) begin
        mv[n] = -1120;
        mw[n] = sat16(wn + 64);
        mr[n] = 2;
        exp_q.push_back(n);
      end else begin
        mv[n] = vn;
        mw[n] = wn;
      end
    end
  endtask

  typedef struct {int cur; int ticks; int ev; int ew; int esp;} vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int pv, pw, rd;
    int want_sw[$];
    tbl = '{
      '{0, 1, -1120, 0, 0}, '{100, 1, -1020, 0, 0}, '{2000, 1, -1120, 64, 1},
      '{1440, 1, -1120, 64, 1}, '{1439, 1, 319, 0, 0}, '{-32768, 1, -32768, 0, 0},
      '{32767, 1, -1120, 64, 1}, '{400, 2, -366, 1, 0}, '{1000, 2, -1120, 67, 1},
      '{-500, 2, -2058, -2, 0}
    };

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_idx", spike_idx, 0);
    chk("rst_drop", spike_drop, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ov_overrun", ov_over, 0);
    for (int n = 0; n < 4; n++) begin
      peek(n, pv, pw);
      chk("rst_v", pv, -1120);
      chk("rst_w", pw, 0);
    end

    repeat (100) sweep();
    settle();
    for (int n = 0; n < 4; n++) begin
      peek(n, pv, pw);
      chk("idle_v", pv, -1120);
      chk("idle_w", pw, 0);
    end
    chk("idle_valid_cycles", valid_cycles, 0);
    chk("idle_overrun", overrun, 0);
    chk("ov_set", ov_over, 1);
    do_reset();
    chk("ov_cleared", ov_over, 0);
    repeat (20) @(posedge clk);
    #1 chk("ov_reset_again", ov_over, 1);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      wr(0, tbl[i].cur);
      repeat (tbl[i].ticks) sweep();
      settle();
      peek(0, pv, pw);
      chk($sformatf("tbl%0d_v", i), pv, tbl[i].ev);
      chk($sformatf("tbl%0d_w", i), pw, tbl[i].ew);
      chk($sformatf("tbl%0d_spk", i), got_q.size(), tbl[i].esp);
      peek(1, pv, pw);
      chk($sformatf("tbl%0d_other", i), pv, -1120);
    end

    do_reset();
    wr(0, 100);
    wait_busy(1'b1);
    wr(0, 2000);
    wait_busy(1'b0);
    settle();
    peek(0, pv, pw);
    chk("midsweep_old_i", pv, -1020);
    chk("midsweep_nospk", got_q.size(), 0);
    sweep();
    settle();
    chk("midsweep_new_i", got_q.size(), 1);

    do_reset();
    spike_ready = 1'b0;
    for (int n = 0; n < 4; n++) wr(n, 2000);
    sweep();
    settle();
    chk("fifo_valid", spike_valid, 1);
    chk("fifo_head", spike_idx, 0);
    chk("fifo_nodrop", spike_drop, 0);
`ifdef ADEX_REFRACTORY_EN
    repeat (3) sweep();
`else
    sweep();
`endif
    settle();
    chk("fifo_drop", spike_drop, 1);
    for (int n = 0; n < 4; n++) wr(n, 0);
    spike_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("fifo_popcount", got_q.size(), 4);
    for (int n = 0; n < 4 && n < got_q.size(); n++) chk("fifo_order", got_q[n], n);
    chk("fifo_empty", spike_valid, 0);
    chk("fifo_drop_sticky", spike_drop, 1);

    do_reset();
    wr(0, 2000);
    repeat (7) sweep();
    settle();
`ifdef ADEX_REFRACTORY_EN
    want_sw = '{1, 4, 7};
`else
    want_sw = '{1, 2, 3, 4, 5, 6, 7};
`endif
    chk("refr_count", got_sw.size(), want_sw.size());
    for (int i = 0; i < want_sw.size() && i < got_sw.size(); i++) begin
      chk("refr_tick", got_sw[i], want_sw[i]);
      chk("refr_idx", got_q[i], 0);
    end

    do_reset();
    for (int n = 0; n < 4; n++) wr(n, 2000);
    wait_busy(1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", spike_valid, 0);
    chk("abort_idx", spike_idx, 0);
    chk("abort_drop", spike_drop, 0);
    chk("abort_overrun", overrun, 0);
    for (int n = 0; n < 4; n++) begin
      peek(n, pv, pw);
      chk("abort_v", pv, -1120);
      chk("abort_w", pw, 0);
    end
    sweep();
    settle();
    chk("abort_cur_cleared", got_q.size(), 0);

    do_reset();
    model_init();
    rd = 0;
    for (int t = 0; t < 40; t++) begin
      int nw;
      nw = int'($urandom_range(3));
      for (int j = 0; j < nw; j++) begin
        int n, c;
        n = int'($urandom_range(3));
        c = int'($urandom_range(3000)) - 600;
        wr(n, c);
        mi[n] = c;
      end
      sweep();
      settle();
      model_tick();
      for (int n = 0; n < 4; n++) begin
        peek(n, pv, pw);
        chk($sformatf("rnd%0d_v%0d", t, n), pv, mv[n]);
        chk($sformatf("rnd%0d_w%0d", t, n), pw, mw[n]);
      end
      while (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        if (rd < got_q.size()) begin
          chk($sformatf("rnd%0d_spk", t), got_q[rd], e);
          rd++;
        end else begin
          chk($sformatf("rnd%0d_spk_missing", t), -1, e);
        end
      end
      chk($sformatf("rnd%0d_spk_count", t), got_q.size(), rd);
    end
    chk("rnd_overrun", overrun, 0);
    chk("rnd_drop", spike_drop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
